// File: rtl/sram_rv_adapter.sv
// sram_rv_adapter: valid/ready request front-end for the sram wrapper.
// Converts accepted requests into SRAM strobes, tracks reads across the
// fixed SRAM read latency and buffers read data in a credit-guarded
// response FIFO, so response back-pressure never loses data.
// Optional feature: define SRAM_ADAPTER_WRITE_ACK_EN to return one
// all-zero response beat per write, in order with reads.
module sram_rv_adapter #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_WORDS    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int RSP_DEPTH    = 3,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    // Pointer, occupancy and credit widths; credits cover FIFO plus pipe.
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int NW = $clog2(RSP_DEPTH + READ_LATENCY + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(RSP_DEPTH);

    // In-flight pipe: one flag per SRAM latency stage.
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
    // Marks in-flight entries that are write acknowledgements.
    logic [READ_LATENCY-1:0] pipe_wr_q, pipe_wr_d;
`endif

    // Response FIFO storage and bookkeeping.
    logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [NW-1:0]         credits_used;
    logic                  credit_ok;
    logic                  accept;
    logic                  take_credit;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits in use from registered state only, so rsp_ready_i never reaches req_ready_o.
    always_comb begin
        credits_used = NW'(count_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            credits_used = credits_used + NW'(pipe_q[i]);
        end
        credit_ok = (credits_used < DEPTH_N);
    end

    // Request handshake, SRAM strobes and response outputs.
    always_comb begin
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
        req_ready_o = ~rst_i & credit_ok;
`else
        req_ready_o = ~rst_i & (req_we_i | credit_ok);
`endif
        accept = req_valid_i & req_ready_o;
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
        take_credit = accept;
`else
        take_credit = accept & ~req_we_i;
`endif
        sram_req_o   = accept;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_be_o    = req_be_i;

        rsp_valid_o = ~rst_i & (count_q != '0);
        pop         = rsp_valid_o & rsp_ready_i;
        rsp_rdata_o = rsp_valid_o ? fifo_mem_q[rd_ptr_q] : '0;

        push = pipe_q[READ_LATENCY-1];
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
        push_data = pipe_wr_q[READ_LATENCY-1] ? '0 : sram_rdata_i;
`else
        push_data = sram_rdata_i;
`endif
    end

    // Next-state for the in-flight pipe and FIFO pointers/occupancy.
    // NOTE: every signal gets its default first, so no path can infer a latch.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = take_credit;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
        pipe_wr_d    = '0;
        pipe_wr_d[0] = req_we_i;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_wr_d[i] = pipe_wr_q[i-1];
        end
`endif
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; reset drops in-flight and buffered data.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q   <= '0;
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
            pipe_wr_q <= '0;
`endif
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pipe_q   <= pipe_d;
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
            pipe_wr_q <= pipe_wr_d;
`endif
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage write at the tail when a tracked beat leaves the pipe.
    // NOTE: storage is not reset; count_q gates its visibility on rsp_rdata_o.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_sram_rv_adapter.sv
// Self-checking bench for sram_rv_adapter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model
// (reference memory, outstanding-response count, expected-beat queue).
module tb_sram_rv_adapter;

    localparam int DW    = 64;
    localparam int NWRD  = 1024;
    localparam int RL    = 1;
    localparam int DEPTH = 3;
    localparam int AW    = $clog2(NWRD);
    localparam int BW    = (DW + 7) / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [BW-1:0] sram_be;
    logic [DW-1:0] sram_rdata;

    always #5 clk = ~clk;

    sram_rv_adapter #(
        .DATA_WIDTH  (DW),
        .NUM_WORDS   (NWRD),
        .READ_LATENCY(RL),
        .RSP_DEPTH   (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_be_o   (sram_be),
        .sram_rdata_i(sram_rdata)
    );

    // Behavioural SRAM macro with RL-cycle read latency.
    logic [DW-1:0] sram_mem [NWRD];
    logic [DW-1:0] rd_pipe  [RL];
    always @(posedge clk) begin
        if (sram_req && sram_we) begin
            for (int b = 0; b < BW; b++) begin
                if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
        if (sram_req && !sram_we) rd_pipe[0] <= sram_mem[sram_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[RL-1];

    // Reference model: memory contents, expected beats, outstanding credits.
    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] ref_mem [NWRD];
    int            outstanding = 0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic          obs_accept;
    logic          obs_beat;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        logic  exp_ready;
        logic  exp_rv;
        beat_t b;
        @(negedge clk);
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
        exp_ready = !rst && (outstanding < DEPTH);
`else
        exp_ready = !rst && (req_we || outstanding < DEPTH);
`endif
        check("req_ready", DW'(req_ready), DW'(exp_ready));
        check("sram_req", DW'(sram_req), DW'(req_valid && exp_ready));
        if (req_valid) begin
            check("sram_addr", DW'(sram_addr), DW'(req_addr));
            check("sram_we", DW'(sram_we), DW'(req_we));
            if (req_we) check("sram_wdata", sram_wdata, req_wdata);
        end
        exp_rv = !rst && (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        check("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
        if (exp_rv) check("rsp_rdata", rsp_rdata, exp_q[0].data);
        if (rst) check("rsp_rdata_rst", rsp_rdata, '0);
        obs_accept = sram_req;
        obs_beat   = rsp_valid && rsp_ready;

        if (rst) begin
            exp_q.delete();
            outstanding = 0;
        end else begin
            if (exp_rv && rsp_ready) begin
                void'(exp_q.pop_front());
                outstanding--;
            end
            if (req_valid && exp_ready) begin
                if (!req_we) begin
                    b.data  = ref_mem[req_addr];
                    b.avail = cyc + RL + 1;
                    exp_q.push_back(b);
                    outstanding++;
                end else begin
                    for (int k = 0; k < BW; k++) begin
                        if (req_be[k]) ref_mem[req_addr][8*k +: 8] = req_wdata[8*k +: 8];
                    end
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
                    b.data  = '0;
                    b.avail = cyc + RL + 1;
                    exp_q.push_back(b);
                    outstanding++;
`endif
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic we, input int addr,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_valid = v;
        req_we    = we;
        req_addr  = AW'(addr);
        req_wdata = d;
        req_be    = be;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, '0);
    endtask

    function automatic logic [DW-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    int acc_cnt;
    int beat_cnt;
    int stall_cnt;
    int budget;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // T1: reset held with a pending read request.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0, '0, '0);
        rst = 1'b0;

        // Initialise addresses 0..15 with full-word writes.
        for (int a = 0; a < 16; a++) drive(1'b1, 1'b1, a, rand64(), '1);
        idle();

        // T2: write then immediately read address 5.
        beat_cnt = 0;
        drive(1'b1, 1'b1, 5, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        drive(1'b1, 1'b0, 5, '0, '0);
        for (int i = 0; i < 4; i++) begin
            idle();
            beat_cnt += int'(obs_beat);
        end
        check("t2_beats", DW'(beat_cnt), DW'(1));

        // T3: 16 back-to-back reads at full throughput.
        stall_cnt = 0;
        beat_cnt  = 0;
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, a, '0, '0);
            stall_cnt += int'(!obs_accept);
            beat_cnt  += int'(obs_beat);
        end
        for (int i = 0; i < 6; i++) begin
            idle();
            beat_cnt += int'(obs_beat);
        end
        check("t3_stalls", DW'(stall_cnt), DW'(0));
        check("t3_beats", DW'(beat_cnt), DW'(16));

        // T4: response back-pressure exhausts credits.
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 8 + i, '0, '0);
            acc_cnt += int'(obs_accept);
        end
        check("t4_reads_accepted", DW'(acc_cnt), DW'(DEPTH));
`ifndef SRAM_ADAPTER_WRITE_ACK_EN
        drive(1'b1, 1'b1, 20, rand64(), '1);
        check("t4_write_accepted", DW'(obs_accept), DW'(1));
`endif
        rsp_ready = 1'b1;
        beat_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            beat_cnt += int'(obs_beat);
        end
        check("t4_beats", DW'(beat_cnt), DW'(DEPTH));

        // T5: reset one cycle after two accepted reads.
        drive(1'b1, 1'b0, 3, '0, '0);
        drive(1'b1, 1'b0, 4, '0, '0);
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        beat_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            beat_cnt += int'(obs_beat);
        end
        check("t5_no_beats", DW'(beat_cnt), DW'(0));
        drive(1'b1, 1'b0, 7, '0, '0);
        for (int i = 0; i < 4; i++) begin
            idle();
            beat_cnt += int'(obs_beat);
        end
        check("t5_beat_after_reset", DW'(beat_cnt), DW'(1));

`ifdef SRAM_ADAPTER_WRITE_ACK_EN
        // T6: write acknowledgements share the response stream and credits.
        beat_cnt = 0;
        drive(1'b1, 1'b1, 9, rand64(), '1);
        drive(1'b1, 1'b0, 9, '0, '0);
        drive(1'b1, 1'b1, 10, rand64(), '1);
        for (int i = 0; i < 6; i++) begin
            idle();
            beat_cnt += int'(obs_beat);
        end
        check("t6_beats", DW'(beat_cnt), DW'(3));
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 11 + i, rand64(), '1);
            acc_cnt += int'(obs_accept);
        end
        check("t6_writes_accepted", DW'(acc_cnt), DW'(DEPTH));
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) idle();
`endif

        // Randomized traffic with back-pressure, partial writes and rare resets.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(63) == 0);
            rsp_ready = ($urandom_range(9) < 7);
            drive($urandom_range(3) != 0, $urandom_range(2) == 0,
                  int'($urandom_range(15)), rand64(), BW'($urandom()));
        end

        // Bounded drain of anything still outstanding.
        rst       = 1'b0;
        rsp_ready = 1'b1;
        budget    = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            idle();
            budget++;
        end
        check("drain_remaining", DW'(exp_q.size()), DW'(0));
        for (int i = 0; i < 3; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
